// File: rtl/key_filter_bank.sv
// rtl/key_filter_bank.sv - multi-channel key debouncer with press/release pulses and optional auto-repeat
// Each channel: 2-flop synchronizer, stability counter, registered level and edge pulses.
module key_filter_bank #(
   parameter int NUM_KEYS   = 4,
   parameter int CNT_MAX    = 999_999,
   parameter int REPEAT_EN  = 0,
   parameter int REPEAT_DLY = 24_999_999,
   parameter int REPEAT_PER = 4_999_999
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_flag,
   output logic [NUM_KEYS-1:0] key_rel
);

   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] pressed;

   // Synchronizer idles high so an idle key never looks like a press out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   assign pressed = ~sync2;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             st;
      logic             flg;
      logic             rel;
      logic             diff;
      logic             accept;
      logic             rpt_fire;

      assign diff   = pressed[i] != st;
      // The edge that would bring cnt to CNT_MAX is the one that flips the level.
      assign accept = diff && (cnt == CNT_W'(CNT_MAX - 1));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
            st  <= 1'b0;
            flg <= 1'b0;
            rel <= 1'b0;
         end else begin
            if (!diff || accept) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
               st <= ~st;
            end
            flg <= (accept && !st) || rpt_fire;
            rel <= accept && st;
         end
      end

      if (REPEAT_EN != 0) begin : g_rpt
         logic [RPT_W-1:0] rcnt;
         logic             rphase;
         logic             hold;

         // Holding means the level is 1 and this edge is not the release edge.
         assign hold     = st && !accept;
         assign rpt_fire = hold && (rcnt == (rphase ? RPT_W'(REPEAT_PER - 1)
                                                    : RPT_W'(REPEAT_DLY - 1)));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rcnt   <= '0;
               rphase <= 1'b0;
            end else if (!hold) begin
               rcnt   <= '0;
               rphase <= 1'b0;
            end else if (rpt_fire) begin
               rcnt   <= '0;
               rphase <= 1'b1;
            end else begin
               rcnt   <= rcnt + RPT_W'(1);
            end
         end
      end else begin : g_no_rpt
         assign rpt_fire = 1'b0;
      end

      assign key_state[i] = st;
      assign key_flag[i]  = flg;
      assign key_rel[i]   = rel;
   end

endmodule

// File: doc/key_filter_bank.md
KEY_FILTER_BANK -- requirements
Module: key_filter_bank

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of independent key channels (1..16).
REQ-002 SHALL have parameter CNT_MAX, default 999_999, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 1.
REQ-003 SHALL have parameter REPEAT_EN, default 0, 1 enables auto-repeat press pulses while a key is held.
REQ-004 SHALL have parameter REPEAT_DLY, default 24_999_999, held cycles after accepted press before the first repeat pulse.
REQ-005 SHALL have parameter REPEAT_PER, default 4_999_999, cycles between subsequent repeat pulses.
REQ-006 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port key_in, input, NUM_KEYS, raw buttons, active-low (idle 1); bit 0 = left, 1 = right, 2 = up, 3 = down at default width.
REQ-009 SHALL have port key_state, output, NUM_KEYS, debounced level, 1 = pressed.
REQ-010 SHALL have port key_flag, output, NUM_KEYS, one-cycle press pulse (press or repeat).
REQ-011 SHALL have port key_rel, output, NUM_KEYS, one-cycle release pulse.

Function
REQ-012 Each key_in bit SHALL pass a 2-flop synchronizer; sync value is visible 2 edges after key_in changes.
REQ-013 Each channel SHALL hold a counter of width $clog2(CNT_MAX+1); counter clears whenever synced (inverted) input equals key_state.
REQ-014 While synced input differs from key_state, counter SHALL increment each cycle; on the edge where it would reach CNT_MAX, key_state SHALL toggle and counter SHALL clear.
REQ-015 Any single-cycle return to the old level before CNT_MAX SHALL clear the counter (no accumulation across glitches).
REQ-016 key_flag[i] SHALL assert for exactly one cycle on the same edge key_state[i] goes 0->1; key_rel[i] likewise on 1->0.
REQ-017 Total latency key_in edge -> key_state/key_flag SHALL be CNT_MAX + 2 cycles for a clean edge.
REQ-018 With REPEAT_EN=1, a held channel SHALL pulse key_flag after REPEAT_DLY cycles from the accepted press, then every REPEAT_PER cycles while key_state stays 1.
REQ-019 Repeat counter SHALL clear on release; no repeat pulse on the release edge; key_rel unaffected by repeat.
REQ-020 With REPEAT_EN=0, repeat logic SHALL not be generated and key_flag pulses only on accepted press.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several keys SHALL yield simultaneous pulses with no priority or masking.
REQ-022 Counters SHALL saturate-free by construction: never exceed CNT_MAX, REPEAT_DLY or REPEAT_PER.

Reset
REQ-023 On rst_n low, asynchronously: synchronizer flops = 1 (idle), all counters = 0, key_state = 0, key_flag = 0, key_rel = 0.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard progress; after release a still-held key needs full CNT_MAX + 2 cycles to be accepted again.
REQ-025 Outputs SHALL not pulse on the first edge after rst_n deasserts while key_in idles high.

Verification (NUM_KEYS=4, CNT_MAX=4, REPEAT_DLY=10, REPEAT_PER=5 unless noted)
REQ-026 key_in[0] 1->0 clean at edge T -> key_state[0]=1 and key_flag[0]=1 at T+6, key_flag[0]=0 at T+7.
REQ-027 key_in[1] low for 3 cycles then high, repeated 5 times -> key_state[1] stays 0, no key_flag/key_rel pulses.
REQ-028 key_in[2] and key_in[3] fall on the same edge -> key_flag = 4'b1100 for one cycle at T+6.
REQ-029 REPEAT_EN=1, key_in[0] held 40 cycles after acceptance -> key_flag[0] pulses at acceptance, +10, +15, +20, +25, +30, +35, +40; release -> single key_rel[0] 6 cycles after key_in returns high, no extra key_flag.
REQ-030 rst_n pulsed low with key_state[0]=1 and key_in[0] held low -> outputs 0 immediately; after rst_n high, key_flag[0] pulses after CNT_MAX + 2 cycles, no key_rel.
